prim_clock_mux2_ctrl: RTL

Sequencing controller that drives the select of a 2:1 clock mux (`prim_clock_mux2`) and the enable of the downstream clock gate so that every clock-source change is glitch-free. It runs on an always-on reference clock. It accepts switch requests over a req/ack pulse handshake. For each switch it:

- gates the muxed clock off,
- waits for the old source to drain,
- flips the select,
- waits for the new source to lock,
- re-enables the gate and acknowledges.

---
 rtl/prim_clock_mux2_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/prim_clock_mux2_ctrl.sv
// rtl/prim_clock_mux2_ctrl.sv - glitch-free clock mux select / gate-enable sequencer
module prim_clock_mux2_ctrl #(
    parameter int   SettleCycles = 4,
    parameter logic ResetSel     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_i,
    input  logic sel_target_i,
    output logic ack_o,
    output logic busy_o,
    output logic sel_o,
    output logic clk_en_o
);

    localparam int CntW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
    localparam logic [CntW-1:0] CntInit = CntW'(SettleCycles - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [1:0] {
        Idle  = 2'd0,
        Drain = 2'd1,
        Lock  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tgt_q, tgt_d;
    logic            sel_d, clk_en_d, busy_d, ack_d;
    logic            cnt_zero, start, fast;

    assign cnt_zero = (cnt_q == '0);
    assign start    = (state_q == Idle) && req_i && (sel_target_i != sel_o);
    assign fast     = (state_q == Idle) && req_i && (sel_target_i == sel_o);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= Idle;
            cnt_q    <= '0;
            tgt_q    <= ResetSel;
            sel_o    <= ResetSel;
            clk_en_o <= 1'b1;
            busy_o   <= 1'b0;
            ack_o    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tgt_q    <= tgt_d;
            sel_o    <= sel_d;
            clk_en_o <= clk_en_d;
            busy_o   <= busy_d;
            ack_o    <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            Idle: begin
                if (start) begin
                    state_d = Drain;
                    cnt_d   = CntInit;
                end
            end
            Drain: begin
                if (cnt_zero) begin
                    state_d = Lock;
                    cnt_d   = CntInit;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            Lock: begin
                if (cnt_zero) begin
                    state_d = Idle;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            default: begin
                state_d = Idle;
                cnt_d   = '0;
            end
        endcase
    end

    // The select only moves at the drain/lock boundary, when the gate is already closed.
    always_comb begin
        tgt_d    = tgt_q;
        sel_d    = sel_o;
        clk_en_d = clk_en_o;
        busy_d   = busy_o;
        ack_d    = 1'b0;
        case (state_q)
            Idle: begin
                if (fast) begin
                    ack_d = 1'b1;
                end else if (start) begin
                    tgt_d    = sel_target_i;
                    clk_en_d = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            Drain: begin
                if (cnt_zero) begin
                    sel_d = tgt_q;
                end
            end
            Lock: begin
                if (cnt_zero) begin
                    clk_en_d = 1'b1;
                    busy_d   = 1'b0;
                    ack_d    = 1'b1;
                end
            end
            default: begin
                clk_en_d = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

endmodule
